calc_seq: RTL

- Parametrised successor to the 16-bit button/switch accumulator calculator.
- Generalised datapath width; 8 operations selected by btnl/btnc/btnr.
- Edge-detected commit button, so one press gives exactly one operation.
- Multi-cycle shift-add multiplier with busy indication.
- Optional undo history stack of configurable depth.
- Sits between board buttons/switches and LEDs; replaces the fixed 16-bit calculator at top level.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_hist_stack.sv | 46 ++++
 rtl/calc_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_seq calculator: op encodings, FSM state type
// and a constant-evaluable ceil(log2) helper.
package calc_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      MULT = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/calc_hist_stack.sv
// Undo history: DEPTH-entry LIFO that overwrites its oldest entry when full.
// top is valid whenever count is non-zero; push and pop are never asserted together.
module calc_hist_stack
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_b,
   input  logic                            push,
   input  logic                            pop,
   input  logic [WIDTH-1:0]                din,
   output logic [WIDTH-1:0]                top,
   output logic [clog2(DEPTH+1)-1:0]       count
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CNT_W = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] ptr_prev;

   // wr_ptr is the slot the next push lands in; the newest entry sits just below it
   assign ptr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
   assign ptr_prev = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
   assign top      = mem[ptr_prev];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= din;
         wr_ptr      <= ptr_next;
         if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
      end else if (pop && count != '0) begin
         wr_ptr <= ptr_prev;
         count  <= count - 1'b1;
      end
   end

endmodule

// File: rtl/calc_seq.sv
// Button/switch accumulator calculator with edge-detected commit and shift-add multiply.
// Undo history is built only when CALC_UNDO_EN is defined.
module calc_seq
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             btnu,
   input  logic             btnl,
   input  logic             btnc,
   input  logic             btnr,
   input  logic             btnd,
   input  logic             btnundo,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] led,
   output logic             busy,
   output logic             ovf
);

   // state | meaning
   // IDLE  | waiting for commit/undo; single-cycle ops complete here
   // MULT  | shift-add multiply running, one iteration per clock, WIDTH clocks

   localparam int SH_W  = clog2(WIDTH);
   localparam int CNT_W = clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btnd_q;
   logic             commit_fire;
   logic             undo_fire;
   logic             hist_avail;
   logic [WIDTH-1:0] hist_top;
   logic             push, pop;
   logic [2:0]       op;
   logic [SH_W-1:0]  sh;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign op          = {btnl, btnc, btnr};
   assign sh          = sw[SH_W-1:0];
   assign commit_fire = btnd & ~btnd_q;
   assign sum         = acc_q + sw;
   assign diff        = acc_q - sw;

`ifdef CALC_UNDO_EN
   localparam int HCNT_W = clog2(DEPTH + 1);

   logic              undo_q;
   logic [HCNT_W-1:0] hist_count;

   assign undo_fire  = btnundo & ~undo_q;
   assign hist_avail = (hist_count != '0);

   always_ff @(posedge clk or negedge btnu) begin
      if (!btnu) undo_q <= 1'b1;
      else       undo_q <= btnundo;
   end

   calc_hist_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_hist (
      .clk   (clk),
      .rst_b (btnu),
      .push  (push),
      .pop   (pop),
      .din   (acc_q),
      .top   (hist_top),
      .count (hist_count)
   );
`else
   localparam int unused_depth = DEPTH;
   logic undo_unused;

   assign undo_fire   = 1'b0;
   assign hist_avail  = 1'b0;
   assign hist_top    = '0;
   assign undo_unused = ^{btnundo, push, pop, hist_top};
`endif

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_AND: alu_res = acc_q & sw;
         OP_OR:  alu_res = acc_q | sw;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (acc_q[WIDTH-1] == sw[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (acc_q[WIDTH-1] != sw[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
         end
         OP_XOR: alu_res = acc_q ^ sw;
         OP_SLL: alu_res = acc_q << sh;
         OP_SRA: alu_res = $signed(acc_q) >>> sh;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            // an undo edge swallows a coincident commit even when there is nothing to undo
            if (undo_fire) begin
               if (hist_avail) begin
                  acc_d = hist_top;
                  ovf_d = 1'b0;
                  pop   = 1'b1;
               end
            end else if (commit_fire) begin
               if (op == OP_MUL) begin
                  mcand_d  = acc_q;
                  mplier_d = sw;
                  prod_d   = '0;
                  cnt_d    = CNT_W'(WIDTH);
                  state_d  = MULT;
               end else begin
                  acc_d = alu_res;
                  ovf_d = alu_ovf;
                  push  = 1'b1;
               end
            end
         end
         MULT: begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               acc_d   = prod_d;
               ovf_d   = 1'b0;
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge btnu) begin
      if (!btnu) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         btnd_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         btnd_q   <= btnd;
      end
   end

   assign led  = acc_q;
   assign busy = (state_q == MULT);
   assign ovf  = ovf_q;

endmodule
